// File: rtl/cic_decimator.sv
// Decimating CIC filter: 1-bit stream -> signed PCM at 1/2^LOG2_DECIM rate; sample lands ORDER+1 edges after frame close.
// Input is never stalled; the output holds one sample and raises sticky overrun when it is overwritten unaccepted.
module cic_decimator #(
  parameter int ORDER      = 4,
  parameter int LOG2_DECIM = 6,
  localparam int ACC_W     = ORDER * LOG2_DECIM + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [ACC_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  input  logic             clear_overrun,
  output logic             overrun
);

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] integ  [ORDER];
  logic signed [ACC_W-1:0] comb_q [ORDER];
  logic signed [ACC_W-1:0] dly    [ORDER];
  logic [LOG2_DECIM-1:0]   cnt;
  logic [ORDER:0]          tok;
  logic                    frame_close;
  logic                    new_sample;

  assign x           = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};
  assign frame_close = bit_valid && (&cnt);
  assign new_sample  = tok[ORDER];

  // Integrators wrap modulo 2^ACC_W; the comb differences cancel the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
      cnt <= '0;
    end else if (bit_valid) begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      cnt <= cnt + 1'b1;
    end
  end

  // Token k marks that stage k fires on the next edge; several may be in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tok <= '0;
    else       tok <= {tok[ORDER-1:0], frame_close};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) begin
        comb_q[k] <= '0;
        dly[k]    <= '0;
      end
      pcm_data <= '0;
    end else begin
      if (tok[0]) comb_q[0] <= integ[ORDER-1];
      for (int k = 1; k < ORDER; k++) begin
        if (tok[k]) begin
          comb_q[k] <= comb_q[k-1] - dly[k-1];
          dly[k-1]  <= comb_q[k-1];
        end
      end
      // The last comb stage writes straight into the output holding register.
      if (tok[ORDER]) begin
        pcm_data       <= comb_q[ORDER-1] - dly[ORDER-1];
        dly[ORDER-1]   <= comb_q[ORDER-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (new_sample)                  pcm_valid <= 1'b1;
      else if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;

      if (new_sample && pcm_valid && !pcm_ready) overrun <= 1'b1;
      else if (clear_overrun)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: default instance plus an R=2 instance, checked every cycle against an arithmetic model.
module tb_cic_decimator;

  localparam int ORD = 4;
  localparam int L2A = 6;
  localparam int WA  = ORD * L2A + 2;
  localparam int L2B = 1;
  localparam int WB  = ORD * L2B + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, bit_in, bit_valid, pcm_ready, clear_overrun;
  logic [WA-1:0] pcm_data;
  logic          pcm_valid, overrun;
  logic          b2, bv2, rdy2, clr2;
  logic [WB-1:0] pcm_data2;
  logic          pcm_valid2, overrun2;

  cic_decimator #(.ORDER(ORD), .LOG2_DECIM(L2A)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .clear_overrun(clear_overrun), .overrun(overrun));

  cic_decimator #(.ORDER(ORD), .LOG2_DECIM(L2B)) dut2 (
    .clk(clk), .reset(reset), .bit_in(b2), .bit_valid(bv2),
    .pcm_data(pcm_data2), .pcm_valid(pcm_valid2), .pcm_ready(rdy2),
    .clear_overrun(clr2), .overrun(overrun2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: plain modular arithmetic on the spec's rules ----------------
  typedef struct {int due; int cfg; longint val;} pend_t;
  pend_t  pq[$];
  longint integ [2][ORD+1];
  longint caps  [2][ORD+1];
  int     mcnt  [2];
  bit     ev_v  [2];
  bit     ev_o  [2];
  longint ev_d  [2];
  longint mlog0[$];
  longint mlog1[$];
  longint dlog0[$];
  int     cyc = 0;
  bit     l0, l1;
  longint v0, v1;

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  // Output of frame n = ORD-th backward difference of I_ORDER captures (zero history).
  task automatic model_bit(input int c, input int l2, input int w, input bit b);
    longint xv, y, coef;
    xv = b ? 1 : -1;
    for (int k = ORD; k >= 2; k--) integ[c][k] = wrapw(integ[c][k] + integ[c][k-1], w);
    integ[c][1] = wrapw(integ[c][1] + xv, w);
    mcnt[c]++;
    if (mcnt[c] == (1 << l2)) begin
      mcnt[c] = 0;
      for (int j = ORD; j >= 1; j--) caps[c][j] = caps[c][j-1];
      caps[c][0] = integ[c][ORD];
      y = 0;
      coef = 1;
      for (int j = 0; j <= ORD; j++) begin
        y += ((j % 2) ? -coef : coef) * caps[c][j];
        coef = coef * (ORD - j) / (j + 1);
      end
      pq.push_back('{due: cyc + ORD + 1, cfg: c, val: wrapw(y, w)});
    end
  endtask

  task automatic model_out(input int c, input bit land, input longint val, input bit rdy, input bit clr);
    bit set_o;
    set_o = land && ev_v[c] && !rdy;
    if (land) begin
      ev_d[c] = val;
      ev_v[c] = 1'b1;
      if (c == 0) mlog0.push_back(val);
      else        mlog1.push_back(val);
    end else if (ev_v[c] && rdy) begin
      ev_v[c] = 1'b0;
    end
    if (set_o)    ev_o[c] = 1'b1;
    else if (clr) ev_o[c] = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k <= ORD; k++) begin
        integ[c][k] = 0;
        caps[c][k]  = 0;
      end
      mcnt[c] = 0;
      ev_v[c] = 1'b0;
      ev_o[c] = 1'b0;
      ev_d[c] = 0;
    end
    pq.delete();
    mlog0.delete();
    mlog1.delete();
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      cyc++;
      l0 = 1'b0; l1 = 1'b0; v0 = 0; v1 = 0;
      while (pq.size() > 0 && pq[0].due == cyc) begin
        if (pq[0].cfg == 0) begin l0 = 1'b1; v0 = pq[0].val; end
        else                begin l1 = 1'b1; v1 = pq[0].val; end
        pq.delete(0);
      end
      model_out(0, l0, v0, pcm_ready, clear_overrun);
      model_out(1, l1, v1, rdy2, clr2);
      if (bit_valid) model_bit(0, L2A, WA, bit_in);
      if (bv2)       model_bit(1, L2B, WB, b2);
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    check("valid0", pcm_valid, ev_v[0]);
    check("data0", $signed(pcm_data), ev_d[0]);
    check("ovr0", overrun, ev_o[0]);
    check("valid1", pcm_valid2, ev_v[1]);
    check("data1", $signed(pcm_data2), ev_d[1]);
    check("ovr1", overrun2, ev_o[1]);
    if (pcm_valid && pcm_ready && !reset) dlog0.push_back($signed(pcm_data));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_valid = 1'b0;
    bv2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    dlog0.delete();
  endtask

  task automatic drive_bit(input bit b, input int gap);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  function automatic bit pat(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 4) != 3;
      default: return (i % 2) == 0;
    endcase
  endfunction

  task automatic run_frames(input int mode, input int nframes, input int gap);
    for (int i = 0; i < nframes * 64; i++) drive_bit(pat(mode, i), gap);
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  // Edges from the frame-closing bit edge until pcm_valid is seen, bounded.
  task automatic latency(output int k);
    k = 0;
    while (!pcm_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  int     lat;
  longint saved[$];

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; pcm_ready = 1'b1; clear_overrun = 1'b0;
    b2 = 1'b0; bv2 = 1'b0; rdy2 = 1'b1; clr2 = 1'b0;
    tick();
    tick();
    check("rst_valid", pcm_valid, 0);
    check("rst_data", $signed(pcm_data), 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;

    // constant ones: first sample C(64,4), then full scale despite wrap
    for (int i = 0; i < 64; i++) drive_bit(1'b1, 1);
    latency(lat);
    check("lat_cont", lat, 5);
    check("first_sample", $signed(pcm_data), 635376);
    run_frames(0, 299, 1);
    settle();
    check("ones_count", mlog0.size(), 300);
    check("ones_idx6", mlog0[5], 16777216);
    check("ones_last", $signed(pcm_data), 16777216);

    // mid-stream reset with a pending sample, overrun and tokens in flight
    pcm_ready = 1'b0;
    run_frames(0, 3, 1);
    tick();
    tick();
    check("pre_rst_ovr", overrun, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", pcm_valid, 0);
    check("mid_rst_data", $signed(pcm_data), 0);
    check("mid_rst_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    pcm_ready = 1'b1;
    dlog0.delete();
    for (int i = 0; i < 63; i++) drive_bit(1'b1, 1);
    repeat (8) tick();
    check("no_early_valid", pcm_valid, 0);
    drive_bit(1'b1, 1);
    latency(lat);
    check("lat_after_rst", lat, 5);
    check("post_rst_first", $signed(pcm_data), 635376);

    do_reset();
    run_frames(1, 20, 1);
    settle();
    check("zeros_idx6", mlog0[5], -16777216);
    check("zeros_last", $signed(pcm_data), -16777216);

    do_reset();
    run_frames(2, 20, 1);
    settle();
    check("p1110_last", $signed(pcm_data), 8388608);
    saved = dlog0;
    check("p1110_count", saved.size(), 20);

    do_reset();
    run_frames(3, 20, 1);
    settle();
    check("alt_last", $signed(pcm_data), 0);

    // same 1110 sequence, bit_valid every third cycle
    do_reset();
    for (int i = 0; i < 1279; i++) drive_bit(pat(2, i), 3);
    drive_bit(pat(2, 1279), 1);
    latency(lat);
    check("lat_gap", lat, 5);
    settle();
    check("gap_count", dlog0.size(), saved.size());
    for (int i = 0; i < saved.size() && i < dlog0.size(); i++) check("gap_sample", dlog0[i], saved[i]);

    // backpressure across two frames, then clear and accept
    do_reset();
    pcm_ready = 1'b0;
    run_frames(0, 2, 1);
    settle();
    check("bp_ovr", overrun, 1);
    check("bp_valid", pcm_valid, 1);
    check("bp_data", $signed(pcm_data), 8126496);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("clr_ovr", overrun, 0);
    check("clr_valid", pcm_valid, 1);
    pcm_ready = 1'b1;
    tick();
    pcm_ready = 1'b0;
    check("acc_valid", pcm_valid, 0);
    check("acc_hold", $signed(pcm_data), 8126496);
    run_frames(0, 1, 1);
    settle();
    check("f3_valid", pcm_valid, 1);
    check("f3_data", $signed(pcm_data), 16010736);

    // ready raised exactly on the landing edge of frame 4
    run_frames(0, 1, 1);
    repeat (4) tick();
    pcm_ready = 1'b1;
    tick();
    check("coin_valid", pcm_valid, 1);
    check("coin_ovr", overrun, 0);
    check("coin_data", $signed(pcm_data), 16777216);
    tick();
    check("coin_accept", pcm_valid, 0);

    // R=2 instance: overlapping tokens
    do_reset();
    b2 = 1'b1;
    bv2 = 1'b1;
    repeat (80) tick();
    bv2 = 1'b0;
    settle();
    check("r2_ones", $signed(pcm_data2), 16);
    b2 = 1'b0;
    bv2 = 1'b1;
    repeat (80) tick();
    bv2 = 1'b0;
    settle();
    check("r2_zeros", $signed(pcm_data2), -16);
    check("r2_count", mlog1.size(), 80);
    check("r2_model_last", mlog1[79], -16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
